regfile_sequencer: RTL and testbench

- Initiator/client for the 8-entry register file. It drives the write port (wen/waddr/wdata) and both read addresses, and consumes the two combinational read data buses.
- Accepts one 2-operand instruction at a time over a valid/ready handshake and performs the read–execute–writeback sequence.
- Returns the result and flags over a valid/ready response handshake.
- Sits between instruction decode and the register file in the 8-bit CPU.

---
 rtl/regfile_sequencer.sv | 168 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - read/execute/writeback sequencer driving an 8-entry register file
// One 2-operand instruction in flight; result and flags returned over a valid/ready response.
module regfile_sequencer #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_dst,
    input  logic [AW-1:0] in_src,
    input  logic [DW-1:0] in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_z,
    output logic          out_c,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [AW-1:0] rf_saddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    input  logic [DW-1:0] rf_sdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] saddr_q, saddr_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] result_q, result_d;
    logic          z_q, z_d;
    logic          c_q, c_d;

    logic [DW-1:0] alu_res;
    logic          alu_c;

    // SUB uses a DW+1 bit difference so the top bit is the borrow (A < B).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_MOV: alu_res = opb_q;
            OP_ADD: {alu_c, alu_res} = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB: {alu_c, alu_res} = {1'b0, opa_q} - {1'b0, opb_q};
            OP_AND: alu_res = opa_q & opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            OP_XOR: alu_res = opa_q ^ opb_q;
            OP_LDI: alu_res = imm_q;
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        imm_d    = imm_q;
        waddr_d  = waddr_q;
        saddr_d  = saddr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    imm_d   = in_imm;
                    waddr_d = in_dst;
                    saddr_d = in_src;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                opa_d   = rf_rdata;
                opb_d   = rf_sdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // NOP reports a zero result but leaves the flags untouched.
                if (op_q == OP_NOP) begin
                    result_d = '0;
                    state_d  = S_RESP;
                end else begin
                    result_d = alu_res;
                    z_d      = (alu_res == '0);
                    c_d      = alu_c;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            imm_q    <= '0;
            waddr_q  <= '0;
            saddr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            waddr_q  <= waddr_d;
            saddr_q  <= saddr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
        end
    end

    // Write enable is decoded straight from state so an async reset kills it at once.
    assign rf_wen     = (state_q == S_WRITE);
    assign rf_waddr   = waddr_q;
    assign rf_saddr   = saddr_q;
    assign rf_wdata   = result_q;
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_RESP);
    assign out_result = result_q;
    assign out_z      = z_q;
    assign out_c      = c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed vector bench for regfile_sequencer with a register file model
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [2:0] in_dst;
    logic [2:0] in_src;
    logic [7:0] in_imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_z;
    logic       out_c;
    logic       rf_wen;
    logic [2:0] rf_waddr;
    logic [2:0] rf_saddr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;
    logic [7:0] rf_sdata;

    logic [7:0] mem [8] = '{default: 8'h00};

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = mem[rf_waddr];
    assign rf_sdata = mem[rf_saddr];

    regfile_sequencer #(.DW(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src(in_src), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_z(out_z), .out_c(out_c),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_saddr(rf_saddr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .rf_sdata(rf_sdata)
    );

    typedef struct {
        logic [2:0] op;
        logic [2:0] dst;
        logic [2:0] src;
        logic [7:0] imm;
        logic [7:0] res;
        logic       z;
        logic       c;
        int         hold;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         wen_cnt, wen_at, valid_at;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       hold_ok;
        int         exp_lat;
        wen_cnt  = 0;
        wen_at   = -1;
        valid_at = -1;
        wa       = '0;
        wd       = '0;
        exp_lat  = (v.op == 3'd7) ? 2 : 3;
        @(negedge clk);
        check($sformatf("v%0d_in_ready_idle", idx), in_ready, 1);
        in_valid = 1'b1;
        in_op    = v.op;
        in_dst   = v.dst;
        in_src   = v.src;
        in_imm   = v.imm;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int cyc = 0; cyc < 12 && valid_at < 0; cyc++) begin
            @(negedge clk);
            if (rf_wen) begin
                wen_cnt++;
                wen_at = cyc;
                wa     = rf_waddr;
                wd     = rf_wdata;
            end
            if (out_valid) valid_at = cyc;
        end
        check($sformatf("v%0d_latency", idx), valid_at, exp_lat);
        check($sformatf("v%0d_wen_count", idx), wen_cnt, (v.op == 3'd7) ? 0 : 1);
        if (v.op != 3'd7) begin
            check($sformatf("v%0d_wen_cycle", idx), wen_at, 2);
            check($sformatf("v%0d_waddr", idx), wa, v.dst);
            check($sformatf("v%0d_wdata", idx), wd, v.res);
        end
        check($sformatf("v%0d_result", idx), out_result, v.res);
        check($sformatf("v%0d_z", idx), out_z, v.z);
        check($sformatf("v%0d_c", idx), out_c, v.c);
        if (v.hold > 0) begin
            hold_ok = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!out_valid || in_ready || rf_wen || out_result !== v.res ||
                    out_z !== v.z || out_c !== v.c) hold_ok = 1'b0;
            end
            check($sformatf("v%0d_hold_stable", idx), hold_ok, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check($sformatf("v%0d_out_valid_drop", idx), out_valid, 0);
        check($sformatf("v%0d_in_ready_after", idx), in_ready, 1);
        if (v.op != 3'd7) check($sformatf("v%0d_rf_value", idx), mem[v.dst], v.res);
    endtask

    initial begin
        int   wen_cnt, valid_at, busy_ready;
        logic ok;

        vecs[0]  = '{3'd6, 3'd1, 3'd0, 8'h7F, 8'h7F, 1'b0, 1'b0, 0};  // LDI R1,7F
        vecs[1]  = '{3'd6, 3'd2, 3'd0, 8'h81, 8'h81, 1'b0, 1'b0, 0};  // LDI R2,81
        vecs[2]  = '{3'd1, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 1'b1, 0};  // ADD R1,R2
        vecs[3]  = '{3'd2, 3'd3, 3'd2, 8'h00, 8'h7F, 1'b0, 1'b1, 0};  // SUB R3,R2
        vecs[4]  = '{3'd5, 3'd3, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 0};  // XOR R3,R3
        vecs[5]  = '{3'd3, 3'd2, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 0};  // AND R2,R1
        vecs[6]  = '{3'd6, 3'd5, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 0};  // LDI R5,F0
        vecs[7]  = '{3'd4, 3'd1, 3'd5, 8'h00, 8'hF0, 1'b0, 1'b0, 0};  // OR  R1,R5
        vecs[8]  = '{3'd0, 3'd6, 3'd1, 8'h00, 8'hF0, 1'b0, 1'b0, 0};  // MOV R6,R1
        vecs[9]  = '{3'd2, 3'd6, 3'd5, 8'h00, 8'h00, 1'b1, 1'b0, 0};  // SUB R6,R5
        vecs[10] = '{3'd1, 3'd5, 3'd5, 8'h00, 8'hE0, 1'b0, 1'b1, 0};  // ADD R5,R5
        vecs[11] = '{3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 0};  // NOP
        vecs[12] = '{3'd2, 3'd1, 3'd5, 8'h00, 8'h10, 1'b0, 1'b0, 0};  // SUB R1,R5
        vecs[13] = '{3'd1, 3'd3, 3'd2, 8'h00, 8'h00, 1'b1, 1'b0, 10}; // ADD R3,R2, stall

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_dst    = '0;
        in_src    = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_rf_wen", rf_wen, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_flags", {out_z, out_c}, 0);
        check("rst_addrs", {rf_waddr, rf_saddr}, 0);
        check("rst_wdata", rf_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // NOP with in_valid held high throughout; the follow-up LDI waits for the handshake.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd7;
        in_dst   = 3'd3;
        in_src   = 3'd3;
        in_imm   = 8'h00;
        @(posedge clk);
        #1;
        wen_cnt = 0; valid_at = -1; busy_ready = 0;
        for (int cyc = 0; cyc < 12 && valid_at < 0; cyc++) begin
            @(negedge clk);
            if (rf_wen) wen_cnt++;
            if (in_ready) busy_ready++;
            if (out_valid) valid_at = cyc;
        end
        check("nop_latency", valid_at, 2);
        check("nop_no_wen", wen_cnt, 0);
        check("nop_busy_not_ready", busy_ready, 0);
        check("nop_result", out_result, 8'h00);
        check("nop_flags_kept", {out_z, out_c}, 2'b10);
        in_op  = 3'd6;
        in_dst = 3'd7;
        in_imm = 8'h3C;
        ok = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            if (in_ready || !out_valid || rf_wen || out_result !== 8'h00) ok = 1'b0;
        end
        check("nop_resp_hold", ok, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("nop_idle_after_hs", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("ldi7_accepted", in_ready, 0);
        valid_at = -1;
        for (int cyc = 0; cyc < 12 && valid_at < 0; cyc++) begin
            @(negedge clk);
            if (out_valid) valid_at = cyc;
        end
        check("ldi7_latency", valid_at, 3);
        check("ldi7_result", out_result, 8'h3C);
        check("ldi7_rf", mem[7], 8'h3C);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset asserted during the WRITE cycle of LDI R4,55.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd6;
        in_dst   = 3'd4;
        in_src   = 3'd0;
        in_imm   = 8'h55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_in_write", rf_wen, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_wen_drop", rf_wen, 0);
        check("rstw_out_valid", out_valid, 0);
        check("rstw_result", out_result, 0);
        check("rstw_flags", {out_z, out_c}, 0);
        check("rstw_addrs", {rf_waddr, rf_saddr}, 0);
        check("rstw_wdata", rf_wdata, 0);
        @(posedge clk);
        #1 check("rstw_r4_kept", mem[4], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstw_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
